spi_flash_word_reader: RTL
==========================

Name: spi_flash_word_reader

Overview:
- SPI master that fetches one 32-bit word per request from an external serial NOR flash using the standard READ command (0x03).
- Sits directly downstream of the OBI SPI ROM front end: the ROM forwards a byte offset on the request channel and consumes the word from the response channel.
- The ROM answers the OBI R channel once this block reports completion.
- The SPI pins connect straight to the chip pads.

Parameters:
- ClkDiv, 2, SCK half-period in clk_i cycles; legal range >= 1.
- CsIdleCycles, 4, minimum number of clk_i cycles spi_cs_n_o stays high between transactions; legal range >= 1.
- ReadCmd, 8'h03, command byte shifted out first.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  read request valid
- req_ready_o  out  1  block can accept a request
- req_addr_i  in  24  flash byte address; bits [1:0] ignored and sent as 0
- rsp_valid_o  out  1  rsp_data_o holds a completed word
- rsp_ready_i  in  1  consumer accepts the word
- rsp_data_o  out  32  fetched word, little-endian
- busy_o  out  1  high in every state except IDLE
- spi_cs_n_o  out  1  flash chip select, active low
- spi_sck_o  out  1  serial clock, SPI mode 0
- spi_mosi_o  out  1  serial data to flash
- spi_miso_i  in  1  serial data from flash

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: spi_cs_n_o=1, spi_sck_o=0, spi_mosi_o=0, rsp_valid_o=0, rsp_data_o=0, req_ready_o=1, busy_o=0, state=IDLE, idle counter saturated (= CsIdleCycles).
- Reset mid-transaction: returns to the reset values in the same instant. CS rising aborts the flash op, and no response is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready_o=1 only when the idle counter >= CsIdleCycles.
  - On req_valid_i & req_ready_o, latch shift_out = {ReadCmd, req_addr_i[23:2], 2'b00} (32 bits) and clear the bit counter.
  - Go to SHIFT.
- SHIFT:
  - spi_cs_n_o=0 for exactly 128*ClkDiv cycles.
  - 64 SCK periods: bits 0-31 are cmd+address, MSB first; bits 32-63 are data.
  - Each period is ClkDiv cycles low, then ClkDiv cycles high.
  - spi_mosi_o changes only while SCK is low and is valid from the first SHIFT cycle. It is 0 during the data bits.
  - spi_miso_i is sampled in the cycle SCK goes 0->1, during data bits only.
  - Received bits are assembled MSB-first per byte. Byte k (k=0..3, in flash address order) lands in rsp_data_o[8k+7:8k].
  - After the 64th falling edge (SCK back to 0), go to DONE.
- DONE:
  - spi_cs_n_o=1, rsp_valid_o=1, and rsp_data_o is stable while rsp_valid_o=1.
  - On rsp_ready_i, go to IDLE.
  - The idle counter restarts at 0 on entry to DONE and increments every cycle while CS is high, saturating at CsIdleCycles.
- Latency: request accepted in cycle 0 means CS low in cycles 1..128*ClkDiv, and rsp_valid_o rises in cycle 128*ClkDiv+1.
- Back-to-back:
  - Combinational ready: with rsp_ready_i tied high, DONE lasts 1 cycle.
  - The next CS fall occurs no earlier than CsIdleCycles cycles after CS rise.
  - Requests are held off via req_ready_o.
- Simultaneous events: a req_valid_i arriving while not in IDLE is not accepted and not lost; the requester holds it. rsp_ready_i outside DONE is ignored.
- SCK glitch-free: spi_sck_o is a registered output and never toggles while CS is high.

Test Plan:
- Reset check: assert rst_ni=0 for 3 cycles -> cs_n=1, sck=0, mosi=0, rsp_valid=0, req_ready=1, busy=0.
- Single read, ClkDiv=2:
  - Stimulus: addr 0x000100; flash model returns 0xEF,0xBE,0xAD,0xDE.
  - MOSI stream: 0x03,0x00,0x01,0x00.
  - Timing: 64 SCK rising edges; CS low for 256 cycles; rsp_valid in cycle 257.
  - Result: rsp_data=0xDEADBEEF.
- Unaligned address: addr 0x000103 -> address bytes on MOSI are 0x00,0x01,0x00; data identical to the 0x000100 read.
- Backpressure and back-to-back:
  - Hold rsp_ready=0 for 10 cycles -> rsp_data stable, req_ready=0, cs_n=1.
  - Then a second pending request at addr 0x000004 -> its CS fall is >= 4 cycles after the first CS rise.
- Reset mid-address phase: rst_ni low at cycle 40 -> cs_n=1 and sck=0 immediately, no rsp_valid. A following read of 0x000100 returns 0xDEADBEEF.
- ClkDiv=1, CsIdleCycles=1: SCK period is 2 cycles, rsp_valid in cycle 129, and the next request is accepted 1 cycle after the DONE handshake.

Source files
------------

// File: rtl/spi_flash_word_reader.sv
// SPI mode-0 master that fetches one little-endian 32-bit word per request from a
// serial NOR flash using the single-wire READ command.
`timescale 1ns/1ps

module spi_flash_word_reader #(
  parameter int unsigned ClkDiv       = 2,
  parameter int unsigned CsIdleCycles = 4,
  parameter logic [7:0]  ReadCmd      = 8'h03
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [23:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        busy_o,
  output logic        spi_cs_n_o,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int unsigned DivW  = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned IdleW = $clog2(CsIdleCycles + 1);
  localparam logic [DivW-1:0]  DivLast = DivW'(ClkDiv - 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(CsIdleCycles);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [31:0]      r_shift_out;
  logic [31:0]      r_rx_data;
  logic [5:0]       r_bit_cnt;
  logic [DivW-1:0]  r_div_cnt;
  logic [IdleW-1:0] r_idle_cnt;
  logic             r_cs_n;
  logic             r_sck;
  logic             r_mosi;

  logic        w_accept;
  logic        w_tick;
  logic        w_rise;
  logic        w_fall;
  logic        w_last_fall;
  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_busy;
  logic [23:0] w_addr_aligned;

  assign w_addr_aligned = req_addr_i & 24'hFF_FFFC;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // w_tick marks the last clk_i cycle of an SCK half-period.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_busy       = 1'b1;
    w_accept     = 1'b0;
    w_tick       = 1'b0;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_last_fall  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy      = 1'b0;
        w_req_ready = (r_idle_cnt >= IdleMax);
        w_accept    = req_valid_i & w_req_ready;
        if (w_accept) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_tick      = (r_div_cnt == DivLast);
        w_rise      = w_tick & ~r_sck;
        w_fall      = w_tick & r_sck;
        w_last_fall = w_fall & (r_bit_cnt == 6'd63);
        if (w_last_fall) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // The command word rotates so every bit stays live; MOSI is forced low once
  // the data phase starts, so the wrapped bits never reach the pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift_out <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
      r_cs_n      <= 1'b1;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
      r_rx_data   <= '0;
    end else if (w_accept) begin
      r_shift_out <= {ReadCmd, w_addr_aligned};
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
      r_cs_n      <= 1'b0;
      r_sck       <= 1'b0;
      r_mosi      <= ReadCmd[7];
    end else if (r_state == SHIFT) begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_rise) begin
        r_sck <= 1'b1;
        if (r_bit_cnt[5]) begin
          r_rx_data[{r_bit_cnt[4:3], ~r_bit_cnt[2:0]}] <= spi_miso_i;
        end
      end
      if (w_fall) begin
        r_sck       <= 1'b0;
        r_bit_cnt   <= r_bit_cnt + 1'b1;
        r_shift_out <= {r_shift_out[30:0], r_shift_out[31]};
        r_mosi      <= (r_bit_cnt < 6'd31) & r_shift_out[30];
        if (w_last_fall) begin
          r_cs_n <= 1'b1;
          r_mosi <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle_cnt <= IdleMax;
    end else if (w_last_fall) begin
      r_idle_cnt <= '0;
    end else if (r_cs_n && (r_idle_cnt != IdleMax)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign req_ready_o = w_req_ready;
  assign rsp_valid_o = w_rsp_valid;
  assign busy_o      = w_busy;
  assign rsp_data_o  = r_rx_data;
  assign spi_cs_n_o  = r_cs_n;
  assign spi_sck_o   = r_sck;
  assign spi_mosi_o  = r_mosi;

endmodule
